// File: rtl/pc_sequencer_if.sv
// Control/address bundle between the decoder/front-end and the program-address sequencer.
// master drives the controls; slave is the sequencer that returns address and status.
interface pc_sequencer_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              run_en;
    logic              step_req;
    logic              step_ack;
    logic              jmp_en;
    logic [1:0]        jmp_cond;
    logic [ADDR_W-1:0] jmp_addr;
    logic              cy_in;
    logic              zero_in;
    logic              halt_in;
    logic [ADDR_W-1:0] addr;
    logic              fetch_valid;
    logic              halted;
    logic              wrapped;
    logic              bad_jmp;

    modport master (
        output run_en, step_req, jmp_en, jmp_cond, jmp_addr, cy_in, zero_in, halt_in,
        input  step_ack, addr, fetch_valid, halted, wrapped, bad_jmp
    );

    modport slave (
        input  run_en, step_req, jmp_en, jmp_cond, jmp_addr, cy_in, zero_in, halt_in,
        output step_ack, addr, fetch_valid, halted, wrapped, bad_jmp
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-address generator: free-run, single-step, conditional jump and halt,
// producing a registered fetch address every clock.
module pc_sequencer #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned PROG_LEN   = 13,
    parameter int unsigned RESET_ADDR = 0
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);

    if (PROG_LEN < 1 || PROG_LEN > (1 << ADDR_W)) begin : g_len_check
        $error("pc_sequencer: PROG_LEN must be in 1..2**ADDR_W");
    end
    if (RESET_ADDR >= PROG_LEN) begin : g_rst_check
        $error("pc_sequencer: RESET_ADDR must be below PROG_LEN");
    end

    localparam logic [ADDR_W-1:0] RST_A  = ADDR_W'(RESET_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(PROG_LEN - 1);
    localparam logic [ADDR_W:0]   LEN_X  = (ADDR_W + 1)'(PROG_LEN);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              step_prev_q, step_prev_d;
    logic              step_ack_q, step_ack_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              halted_q, halted_d;
    logic              wrapped_q, wrapped_d;
    logic              bad_jmp_q, bad_jmp_d;

    logic              cond_ok;
    logic              taken;
    logic [ADDR_W-1:0] na;
    logic              na_bad;
    logic              na_wrap;
    logic              step_edge;
    logic              advance;

    // Next-address function; flags are only committed when the address actually advances.
    always_comb begin
        cond_ok = 1'b0;
        na      = addr_q + ADDR_W'(1);
        na_bad  = 1'b0;
        na_wrap = 1'b0;
        case (bus.jmp_cond)
            2'b00:   cond_ok = 1'b1;
            2'b01:   cond_ok = bus.cy_in;
            2'b10:   cond_ok = ~bus.cy_in;
            default: cond_ok = bus.zero_in;
        endcase
        taken = bus.jmp_en & cond_ok;
        if (taken) begin
            if ({1'b0, bus.jmp_addr} < LEN_X) begin
                na = bus.jmp_addr;
            end else begin
                na     = RST_A;
                na_bad = 1'b1;
            end
        end else if (addr_q == LAST_A) begin
            na      = RST_A;
            na_wrap = 1'b1;
        end
    end

    assign step_edge = bus.step_req & ~step_prev_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        step_ack_d    = 1'b0;
        fetch_valid_d = 1'b0;
        halted_d      = halted_q;
        wrapped_d     = wrapped_q;
        bad_jmp_d     = bad_jmp_q;
        // Edge detector tracks every cycle so edges seen in RUN or HALTED are never queued.
        step_prev_d   = bus.step_req;
        advance       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.run_en) begin
                    state_d       = ST_RUN;
                    fetch_valid_d = 1'b1;
                end else if (step_edge) begin
                    step_ack_d = 1'b1;
                    if (bus.halt_in) begin
                        state_d  = ST_HALTED;
                        halted_d = 1'b1;
                    end else begin
                        advance       = 1'b1;
                        fetch_valid_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (bus.halt_in) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end else if (!bus.run_en) begin
                    state_d = ST_IDLE;
                end else begin
                    advance       = 1'b1;
                    fetch_valid_d = 1'b1;
                end
            end
            ST_HALTED: begin
                halted_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (advance) begin
            addr_d    = na;
            wrapped_d = wrapped_q | na_wrap;
            bad_jmp_d = bad_jmp_q | na_bad;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            addr_q        <= RST_A;
            step_prev_q   <= 1'b0;
            step_ack_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            wrapped_q     <= 1'b0;
            bad_jmp_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            step_prev_q   <= step_prev_d;
            step_ack_q    <= step_ack_d;
            fetch_valid_q <= fetch_valid_d;
            halted_q      <= halted_d;
            wrapped_q     <= wrapped_d;
            bad_jmp_q     <= bad_jmp_d;
        end
    end

    assign bus.addr        = addr_q;
    assign bus.step_ack    = step_ack_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.halted      = halted_q;
    assign bus.wrapped     = wrapped_q;
    assign bus.bad_jmp     = bad_jmp_q;

endmodule
